hs_skid_pipe: RTL and testbench
===============================

# hs_skid_pipe

Parametrised valid/ready pipeline of DEPTH skid-buffer stages, carrying a DATA_W-bit payload from an upstream producer to a downstream consumer. Each stage registers both data and ready, so it sustains one beat per cycle under continuous flow and breaks the combinational ready path between neighbours. The block sits between bus masters and slaves wherever the handshake path needs retiming. It also adds synchronous flush, an occupancy count and optional transfer statistics.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 2, number of skid stages (≥1)
- CNT_W, 16, width of the statistics counters
- sys_clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream beat valid
- s_data  in  DATA_W  upstream payload
- s_ready  out  1  block accepts a beat this cycle
- m_valid  out  1  downstream beat valid
- m_data  out  DATA_W  downstream payload
- m_ready  in  1  downstream accepts a beat
- flush  in  1  synchronous discard of all held beats
- occupancy  out  $clog2(2*DEPTH+1)  beats currently held (0..2*DEPTH)
- beat_cnt  out  CNT_W  beats delivered downstream (statistics)
- stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0 (statistics)

## Operation
- Transfer ("fire") occurs on a rising edge when valid=1 and ready=1 on the same interface. s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Stage k's output feeds stage k+1's input. Stage 0 faces s_*; stage DEPTH-1 faces m_*.
- Each stage holds a main register and a skid register and has three states:
  - EMPTY: in_ready=1, out_valid=0.
    - in fire: main←in → BUSY.
  - BUSY: in_ready=1, out_valid=1, out_data=main.
    - in and out fire together: main←in, stay BUSY.
    - in fire only: skid←in → FULL.
    - out fire only → EMPTY.
  - FULL: in_ready=0, out_valid=1, out_data=main.
    - out fire: main←skid → BUSY. No input is accepted in FULL.
- in_ready is decoded from registered state only and never depends on same-cycle out_ready.
- Ordering is strict FIFO. No beat is dropped or duplicated except by flush.
- flush=1: s_ready and m_valid are forced 0 that cycle, so no fire occurs on either side. Every stage goes to EMPTY at the next edge and occupancy goes to 0. Data registers keep their values.
- occupancy: next = occupancy + s_fire − m_fire; flush forces 0.
- m_data is a plain register output, never high-impedance. It holds its last value while m_valid=0.

## Timing
- Reset values:
  - all stages EMPTY
  - s_ready=1, m_valid=0, m_data=0, occupancy=0
  - beat_cnt=0, stall_cnt=0
- Latency: a beat accepted at edge t with no stalls appears as m_valid=1 in the cycle after edge t+DEPTH−1, i.e. DEPTH cycles of latency.
- Throughput: 1 beat/cycle sustained while m_ready=1.
- Backpressure: after m_ready drops, s_ready falls after at most 2·DEPTH−occupancy accepted beats. The pipe absorbs up to 2·DEPTH beats.
- Deassert/reassert of m_ready causes no bubble beyond one cycle per stage refilling from skid.
- rst_n asserted mid-transfer discards all beats immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.
- flush and rst_n are both independent of m_ready.

## Configuration
- HS_SKID_PIPE_STATS_EN defined:
  - beat_cnt increments on each m_fire.
  - stall_cnt increments on each cycle with m_valid & !m_ready.
  - Both saturate at 2^CNT_W−1, are unaffected by flush, and clear only on reset.
- HS_SKID_PIPE_STATS_EN undefined: counter logic is absent, and beat_cnt and stall_cnt are tied to 0. The port list is identical in both builds.

## Structure
- Shared package hs_pkg holds:
  - stage state enum (ST_EMPTY, ST_BUSY, ST_FULL)
  - helper constant function for the occupancy width
- Sub-module hs_skid_stage: one stage (state, main, skid; DATA_W parameter; flush input). The top instantiates DEPTH copies in a generate loop and adds the occupancy and statistics logic.

## Test plan
- Reset: hold rst_n=0, then release → s_ready=1, m_valid=0, occupancy=0, counters 0.
- DEPTH=2, m_ready=1, stream s_data 0x01..0x10 back-to-back → m_data 0x01..0x10 in order, first valid 2 cycles after first accept, 16 consecutive valid cycles, beat_cnt=16.
- DEPTH=2, m_ready=0, s_valid=1 continuously → exactly 4 beats accepted, s_ready=0, occupancy=4. Then m_ready=1 → the 4 beats drain in order, then streaming resumes.
- Random s_valid/m_ready at 50% each, 10,000 beats → scoreboard matches, no loss or duplication, occupancy always equals accepted minus delivered.
- Fill to occupancy 3, assert flush for one cycle with s_valid=1 and m_ready=1 → no fire that cycle, occupancy=0 next cycle, the offered beat is not accepted.
- Stats build: m_valid held with m_ready=0 for 5 cycles → stall_cnt=5. With CNT_W=4, deliver 20 beats → beat_cnt saturates at 15.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types for the skid-buffer pipeline: per-stage state encoding and
// the occupancy width helper used by the top-level port list.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Occupancy spans 0..2*depth inclusive (main + skid per stage).
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/hs_skid_stage.sv
// One valid/ready skid stage: main + skid registers, ready decoded from
// registered state only so the downstream ready path is cut here.
module hs_skid_stage
  import hs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  stage_state_e      state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    in_fire    = in_valid & in_ready;
    out_fire   = out_valid & out_ready;
    // Flush empties the stage but leaves the data registers untouched.
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            main_next  = in_data;
            state_next = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            skid_next  = in_data;
            state_next = ST_FULL;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_next  = skid_reg;
            state_next = ST_BUSY;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/hs_skid_pipe.sv
// DEPTH-stage valid/ready retiming pipe with flush, occupancy count and
// optional delivery/stall statistics (enabled by HS_SKID_PIPE_STATS_EN).
module hs_skid_pipe
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_ready,
  input  logic                        flush,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [CNT_W-1:0]            beat_cnt,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int OCC_W = occ_width(DEPTH);

  logic              link_valid [DEPTH+1];
  logic              link_ready [DEPTH+1];
  logic [DATA_W-1:0] link_data  [DEPTH+1];

  assign link_valid[0]     = s_valid;
  assign link_data[0]      = s_data;
  assign link_ready[DEPTH] = m_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      hs_skid_stage #(
        .DATA_W(DATA_W)
      ) u_stage (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (link_valid[gi]),
        .in_data  (link_data[gi]),
        .in_ready (link_ready[gi]),
        .out_valid(link_valid[gi+1]),
        .out_data (link_data[gi+1]),
        .out_ready(link_ready[gi+1])
      );
    end
  endgenerate

  // Flush blocks both handshakes so nothing transfers in the flush cycle.
  assign s_ready = link_ready[0] & ~flush;
  assign m_valid = link_valid[DEPTH] & ~flush;
  assign m_data  = link_data[DEPTH];

  logic             s_fire;
  logic             m_fire;
  logic [OCC_W-1:0] occ_reg, occ_next;

  assign s_fire    = s_valid & s_ready;
  assign m_fire    = m_valid & m_ready;
  assign occupancy = occ_reg;

  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = occ_reg + OCC_W'(s_fire) - OCC_W'(m_fire);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

`ifdef HS_SKID_PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] beat_reg;
  logic [CNT_W-1:0] stall_reg;
  logic             stall;

  assign stall = m_valid & ~m_ready;

  // Saturating counters; flush does not touch them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      stall_reg <= '0;
    end else begin
      if (m_fire && (beat_reg != CNT_MAX)) begin
        beat_reg <= beat_reg + CNT_W'(1);
      end
      if (stall && (stall_reg != CNT_MAX)) begin
        stall_reg <= stall_reg + CNT_W'(1);
      end
    end
  end

  assign beat_cnt  = beat_reg;
  assign stall_cnt = stall_reg;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_skid_pipe.sv
// Self-checking bench for hs_skid_pipe: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_hs_skid_pipe;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int OCC_W   = $clog2(2 * DEPTH + 1);
  localparam int CAP     = 2 * DEPTH;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HS_SKID_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b1;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic              flush   = 1'b0;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  hs_skid_pipe #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .flush    (flush),
    .occupancy(occupancy),
    .beat_cnt (beat_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO of accepted beats, counters from the stats rules.
  logic [DATA_W-1:0] exp_q[$];
  int                exp_beat;
  int                exp_stall;
  logic              prev_mvalid;
  logic [DATA_W-1:0] prev_mdata;

  initial begin
    exp_beat    = 0;
    exp_stall   = 0;
    prev_mvalid = 1'b0;
    prev_mdata  = '0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_beat    = 0;
        exp_stall   = 0;
        prev_mvalid = 1'b0;
        prev_mdata  = '0;
      end else if (mon_en) begin
        check("occupancy", occupancy, exp_q.size());
        check("beat_cnt", beat_cnt, STATS ? exp_beat : 0);
        check("stall_cnt", stall_cnt, STATS ? exp_stall : 0);
        if (flush) begin
          check("flush_s_ready", s_ready, 0);
          check("flush_m_valid", m_valid, 0);
        end else if (exp_q.size() == CAP) begin
          check("s_ready_full", s_ready, 0);
        end else if (exp_q.size() == 0) begin
          check("s_ready_empty", s_ready, 1);
          check("m_valid_empty", m_valid, 0);
        end
        if (m_valid) begin
          if (exp_q.size() == 0) check("m_valid_no_beat", m_valid, 0);
          else check("m_data_order", m_data, exp_q[0]);
        end
        if (!prev_mvalid && !m_valid) check("m_data_hold", m_data, prev_mdata);
        if (m_valid && m_ready && exp_q.size() > 0) begin
          $display("[TB] beat data=%02h occ=%0d", m_data, occupancy);
          void'(exp_q.pop_front());
          if (exp_beat < CNT_MAX) exp_beat++;
        end
        if (m_valid && !m_ready && exp_stall < CNT_MAX) exp_stall++;
        if (flush) exp_q.delete();
        else if (s_valid && s_ready) exp_q.push_back(s_data);
        prev_mvalid = m_valid;
        prev_mdata  = m_data;
      end
    end
  end

  task automatic drive_cycle(input logic sv, input logic [DATA_W-1:0] sd, input logic mr,
                             input logic fl, output logic sf, output logic mf);
    @(posedge sys_clk);
    #1;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge sys_clk);
    sf = s_valid & s_ready;
    mf = m_valid & m_ready;
  endtask

  // Asynchronous reset asserted between edges; outputs must settle at once.
  task automatic do_reset();
    @(posedge sys_clk);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge sys_clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  logic              sf, mf, cur_v;
  logic [DATA_W-1:0] seq;
  logic [DATA_W-1:0] got [32];
  int                first_acc, first_val, last_val, nval, nacc, delivered, cycles;
  bit                seen;

  initial begin
    do_reset();

    // Back-to-back stream with m_ready held high.
    first_acc = -1; first_val = -1; last_val = -1; nval = 0;
    for (int c = 0; c < 24; c++) begin
      drive_cycle(c < 16, DATA_W'(c + 1), 1'b1, 1'b0, sf, mf);
      if (sf && first_acc < 0) first_acc = c;
      if (m_valid) begin
        if (first_val < 0) first_val = c;
        last_val  = c;
        got[nval] = m_data;
        nval++;
      end
    end
    check("stream_latency", first_val - first_acc, 2);
    check("stream_count", nval, 16);
    check("stream_run", last_val - first_val + 1, 16);
    check("stream_first", got[0], 8'h01);
    check("stream_last", got[15], 8'h10);
    check("stream_beat_cnt", beat_cnt, STATS ? 15 : 0);

    // Backpressure: absorb exactly 2*DEPTH beats, then drain in order.
    do_reset();
    for (int i = 0; i < 32; i++) got[i] = '0;
    seq = 8'hA0; nacc = 0;
    for (int c = 0; c < 7; c++) begin
      drive_cycle(1'b1, seq, 1'b0, 1'b0, sf, mf);
      if (sf) begin
        seq++;
        nacc++;
      end
    end
    check("bp_accepted", nacc, 4);
    check("bp_s_ready", s_ready, 0);
    check("bp_occupancy", occupancy, 4);
    check("bp_m_valid", m_valid, 1);
    nval = 0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b1, seq, 1'b1, 1'b0, sf, mf);
      if (c == 0) check("bp_stall_cnt", stall_cnt, STATS ? 5 : 0);
      if (sf) seq++;
      if (mf) begin
        got[nval] = m_data;
        nval++;
      end
    end
    check("drain_first", got[0], 8'hA0);
    check("drain_fourth", got[3], 8'hA3);
    check("drain_resume", got[4], 8'hA4);
    check("drain_eighth", got[7], 8'hA7);
    check("drain_count", nval, 12);

    // Reset while streaming, then flush with three beats held.
    do_reset();
    seq = 8'h30;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, seq, 1'b0, 1'b0, sf, mf);
      if (sf) seq++;
    end
    drive_cycle(1'b0, seq, 1'b0, 1'b0, sf, mf);
    check("flush_pre_occ", occupancy, 3);
    drive_cycle(1'b1, 8'hEE, 1'b1, 1'b1, sf, mf);
    check("flush_no_s_fire", sf, 0);
    check("flush_no_m_fire", mf, 0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, sf, mf);
    check("flush_post_occ", occupancy, 0);
    check("flush_post_m_valid", m_valid, 0);
    drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, sf, mf);
    check("flush_new_accept", sf, 1);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, sf, mf);
      if (mf) begin
        seen = 1'b1;
        check("flush_next_data", m_data, 8'h55);
      end
    end
    check("flush_delivered", seen, 1);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, sf, mf);
    check("flush_beat_cnt", beat_cnt, STATS ? 1 : 0);

    // Random 50% valid / 50% ready traffic, 10000 beats, bounded by cycles.
    do_reset();
    seq = '0; delivered = 0; cycles = 0; cur_v = 1'b0;
    while (delivered < 10000 && cycles < 60000) begin
      if (!cur_v) cur_v = 1'($urandom_range(0, 1));
      drive_cycle(cur_v, seq, 1'($urandom_range(0, 1)), 1'b0, sf, mf);
      if (sf) begin
        seq++;
        cur_v = 1'b0;
      end
      if (mf) delivered++;
      cycles++;
    end
    check("random_delivered", delivered, 10000);

    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, sf, mf);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
